// File: rtl/sw_arm_sync_gen.sv
// ---------------------------------------------------------------------------
// sw_arm_sync_gen
//
// Turns the software control word into sync pulses for the F-engine pipeline
// (PFB / FFT / packetiser). Software arms the block with a rising ARM bit.
// An armed block fires on the next external sync edge (1PPS) or on a rising
// FORCE bit. It then emits one pulse, or a pulse every PERIOD cycles, until
// STOP or re-ARM.
//
// Control word: bit0 ARM, bit1 FORCE, bit2 STOP, bits[31:8] PERIOD
// (cycles, 0 = one-shot). Only rising edges of ARM/FORCE/STOP are acted on.
//
// Ports:
//   user_clk      fabric clock, all logic on the rising edge
//   user_rst      asynchronous active-high reset
//   user_data_in  32-bit control word, synchronous to user_clk
//   ext_sync_in   external sync, synchronous to user_clk, any width
//   sync_out      sync pulse, PULSE_LEN cycles per start (merges on overlap)
//   armed         high while waiting for a trigger
//   running       high while emitting periodic pulses
//   sync_count    number of pulse starts, wraps at 2^CNT_W
//   status_out    {sync_count[15:0], 12'b0, running, armed, 2'b00}
// ---------------------------------------------------------------------------
module sw_arm_sync_gen #(
    parameter int PULSE_LEN = 1,
    parameter int CNT_W     = 16
) (
    input  logic             user_clk,
    input  logic             user_rst,
    input  logic [31:0]      user_data_in,
    input  logic             ext_sync_in,
    output logic             sync_out,
    output logic             armed,
    output logic             running,
    output logic [CNT_W-1:0] sync_count,
    output logic [31:0]      status_out
);

    localparam logic [7:0] PULSE_LEN_C = 8'(PULSE_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2
    } state_t;

    state_t             state_reg;
    logic [2:0]         bits_q_reg;      // {STOP, FORCE, ARM} as captured
    logic [2:0]         bits_prev_reg;
    logic [23:0]        period_q_reg;
    logic               ext_prev_reg;
    logic [23:0]        per_lat_reg;
    logic [23:0]        per_cnt_reg;
    logic [7:0]         pulse_cnt_reg;
    logic [7:0]         pulse_cnt_next;
    logic               sync_out_reg;
    logic [CNT_W-1:0]   sync_count_reg;

    logic               arm_rise;
    logic               force_rise;
    logic               stop_rise;
    logic               ext_rise;
    logic               trigger;
    logic               start_pulse;
    logic [15:0]        count_16;

    // Bits [7:3] of the control word carry no meaning here.
    logic               unused_ctrl_bits;
    assign unused_ctrl_bits = ^user_data_in[7:3];

    // Control edges come from the registered copy; the external sync is
    // compared live against its one-cycle delay so it fires on the same edge
    // that first samples it high.
    assign arm_rise   = bits_q_reg[0] & ~bits_prev_reg[0];
    assign force_rise = bits_q_reg[1] & ~bits_prev_reg[1];
    assign stop_rise  = bits_q_reg[2] & ~bits_prev_reg[2];
    assign ext_rise   = ext_sync_in & ~ext_prev_reg;
    assign trigger    = ext_rise | force_rise;

    // STOP beats everything; in RUNNING a re-ARM also swallows the expiry.
    always_comb begin
        start_pulse = 1'b0;
        case (state_reg)
            ARMED:   start_pulse = ~stop_rise & trigger;
            RUNNING: start_pulse = ~stop_rise & ~arm_rise & (per_cnt_reg == 24'd0);
            default: start_pulse = 1'b0;
        endcase
    end

    // The pulse counter is independent of the FSM so a pulse always completes
    // once started; a new start reloads it, merging overlapping pulses.
    always_comb begin
        pulse_cnt_next = pulse_cnt_reg;
        if (start_pulse) begin
            pulse_cnt_next = PULSE_LEN_C;
        end else if (pulse_cnt_reg != 8'd0) begin
            pulse_cnt_next = pulse_cnt_reg - 8'd1;
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_reg      <= IDLE;
            bits_q_reg     <= 3'b000;
            bits_prev_reg  <= 3'b000;
            period_q_reg   <= 24'd0;
            ext_prev_reg   <= 1'b0;
            per_lat_reg    <= 24'd0;
            per_cnt_reg    <= 24'd0;
            pulse_cnt_reg  <= 8'd0;
            sync_out_reg   <= 1'b0;
            sync_count_reg <= '0;
        end else begin
            bits_q_reg     <= {user_data_in[2], user_data_in[1], user_data_in[0]};
            bits_prev_reg  <= bits_q_reg;
            period_q_reg   <= user_data_in[31:8];
            ext_prev_reg   <= ext_sync_in;
            pulse_cnt_reg  <= pulse_cnt_next;
            sync_out_reg   <= (pulse_cnt_next != 8'd0);
            if (start_pulse) begin
                sync_count_reg <= sync_count_reg + CNT_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (arm_rise) begin
                        state_reg <= ARMED;
                    end
                end
                ARMED: begin
                    if (stop_rise) begin
                        state_reg <= IDLE;
                    end else if (trigger) begin
                        // PERIOD is frozen here; later writes wait for the
                        // next trigger.
                        per_lat_reg <= period_q_reg;
                        per_cnt_reg <= period_q_reg - 24'd1;
                        state_reg   <= (period_q_reg != 24'd0) ? RUNNING : IDLE;
                    end
                end
                RUNNING: begin
                    if (stop_rise) begin
                        state_reg <= IDLE;
                    end else if (arm_rise) begin
                        state_reg <= ARMED;
                    end else if (per_cnt_reg == 24'd0) begin
                        per_cnt_reg <= per_lat_reg - 24'd1;
                    end else begin
                        per_cnt_reg <= per_cnt_reg - 24'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        if (CNT_W >= 16) begin : g_cnt_trunc
            assign count_16 = sync_count_reg[15:0];
        end else begin : g_cnt_pad
            assign count_16 = {{(16 - CNT_W){1'b0}}, sync_count_reg};
        end
    endgenerate

    assign sync_out   = sync_out_reg;
    assign armed      = (state_reg == ARMED);
    assign running    = (state_reg == RUNNING);
    assign sync_count = sync_count_reg;
    assign status_out = {count_16, 12'd0, running, armed, 2'b00};

endmodule

// File: tb/tb_sw_arm_sync_gen.sv
module tb_sw_arm_sync_gen;

    localparam int PULSE_LEN = 4;
    localparam int CNT_W     = 4;

    logic             user_clk = 1'b0;
    logic             user_rst;
    logic [31:0]      user_data_in;
    logic             ext_sync_in;
    logic             sync_out;
    logic             armed;
    logic             running;
    logic [CNT_W-1:0] sync_count;
    logic [31:0]      status_out;

    sw_arm_sync_gen #(.PULSE_LEN(PULSE_LEN), .CNT_W(CNT_W)) dut (
        .user_clk     (user_clk),
        .user_rst     (user_rst),
        .user_data_in (user_data_in),
        .ext_sync_in  (ext_sync_in),
        .sync_out     (sync_out),
        .armed        (armed),
        .running      (running),
        .sync_count   (sync_count),
        .status_out   (status_out)
    );

    always #5 user_clk = ~user_clk;

    int cyc = 0;
    always @(posedge user_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int start;
        int width;
        int cnt;
    } pulse_t;
    pulse_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int start, input int width, input int cnt);
        pulse_t p;
        p.start = start;
        p.width = width;
        p.cnt   = cnt;
        exp_q.push_back(p);
    endtask

    // Monitor: measures each sync_out pulse and compares it to the next
    // expected record when the pulse ends.
    logic mon_prev = 1'b0;
    int   mon_start = 0;
    int   mon_width = 0;
    int   mon_cnt = 0;
    always @(negedge user_clk) begin
        if (sync_out && !mon_prev) begin
            mon_start = cyc;
            mon_width = 1;
            mon_cnt   = int'(sync_count);
        end else if (sync_out) begin
            mon_width++;
        end else if (mon_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got start %0d width %0d required none", mon_start, mon_width);
            end else begin
                pulse_t e;
                e = exp_q.pop_front();
                chk("pulse_start", 32'(mon_start), 32'(e.start));
                chk("pulse_width", 32'(mon_width), 32'(e.width));
                chk("pulse_count", 32'(mon_cnt), 32'(e.cnt));
            end
            $display("pulse start=%0d width=%0d count=%0d", mon_start, mon_width, mon_cnt);
        end
        mon_prev = sync_out;
    end

    task automatic go(input int t);
        while (cyc < t) @(negedge user_clk);
    endtask

    task automatic wr(input logic [31:0] v, output int c);
        @(negedge user_clk);
        user_data_in = v;
        c = cyc;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, d, e, f, h, j, m, r, k;
        user_rst = 1'b1;
        user_data_in = 32'd0;
        ext_sync_in = 1'b0;
        repeat (3) @(negedge user_clk);
        chk("rst_sync_out", 32'(sync_out), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_count", 32'(sync_count), 32'd0);
        chk("rst_status", status_out, 32'h0000_0000);
        user_rst = 1'b0;

        // External sync while idle is ignored.
        repeat (2) begin
            @(negedge user_clk) ext_sync_in = 1'b1;
            @(negedge user_clk) ext_sync_in = 1'b0;
        end
        @(negedge user_clk);
        chk("idle_armed", 32'(armed), 32'd0);
        chk("idle_status", status_out, 32'h0000_0000);

        // One-shot external trigger.
        wr(32'h1, c);
        go(c + 1);
        chk("arm_latency", 32'(armed), 32'd0);
        go(c + 2);
        chk("oneshot_armed", 32'(armed), 32'd1);
        chk("oneshot_armed_status", status_out, 32'h0000_0004);
        @(negedge user_clk);
        ext_sync_in = 1'b1;
        d = cyc;
        push(d + 1, 4, 1);
        go(d + 1);
        chk("oneshot_idle", 32'({running, armed}), 32'd0);
        chk("oneshot_count", 32'(sync_count), 32'd1);
        chk("oneshot_status", status_out, 32'h0001_0000);
        go(d + 3);
        ext_sync_in = 1'b0;
        wr(32'h0, c);
        go(c + 6);

        // Periodic, PERIOD = 10, forced start.
        wr(32'h0000_0A01, c);
        go(c + 2);
        chk("per_armed", 32'(armed), 32'd1);
        wr(32'h0000_0A03, e);
        for (int i = 0; i < 5; i++) push(e + 2 + 10 * i, 4, 2 + i);
        go(e + 2);
        chk("per_running", 32'(running), 32'd1);
        chk("per_status", status_out, 32'h0002_0008);
        go(e + 45);
        user_data_in = 32'h0000_0A07;
        go(e + 46);
        chk("per_stop_latency", 32'(running), 32'd1);
        go(e + 47);
        chk("per_stopped", 32'({running, armed}), 32'd0);
        chk("per_count", 32'(sync_count), 32'd6);
        chk("per_stop_status", status_out, 32'h0006_0000);
        go(e + 60);

        // FORCE and ext edge together give one pulse.
        wr(32'h0, c);
        wr(32'h1, c);
        go(c + 2);
        wr(32'h3, f);
        go(f + 1);
        ext_sync_in = 1'b1;
        push(f + 2, 4, 7);
        go(f + 2);
        chk("dual_trig_idle", 32'({running, armed}), 32'd0);
        chk("dual_trig_count", 32'(sync_count), 32'd7);
        go(f + 4);
        ext_sync_in = 1'b0;

        // STOP beats an ext edge in ARMED.
        wr(32'h0, c);
        wr(32'h1, c);
        go(c + 2);
        chk("stop_pre_armed", 32'(armed), 32'd1);
        wr(32'h5, h);
        go(h + 1);
        ext_sync_in = 1'b1;
        go(h + 2);
        chk("stop_vs_ext_state", 32'({running, armed}), 32'd0);
        chk("stop_vs_ext_out", 32'(sync_out), 32'd0);
        go(h + 4);
        ext_sync_in = 1'b0;
        go(h + 8);
        chk("stop_vs_ext_count", 32'(sync_count), 32'd7);

        // Re-ARM on the expiry cycle of RUNNING: back to ARMED, no pulse.
        wr(32'h0, c);
        wr(32'h0000_0501, c);
        go(c + 2);
        wr(32'h0000_0503, j);
        push(j + 2, 4, 8);
        go(j + 2);
        chk("rearm_running", 32'(running), 32'd1);
        go(j + 4);
        user_data_in = 32'h0000_0502;
        go(j + 5);
        user_data_in = 32'h0000_0503;
        go(j + 7);
        chk("rearm_state", 32'({running, armed}), 32'd1);
        go(j + 20);
        chk("rearm_count", 32'(sync_count), 32'd8);
        wr(32'h0000_0507, c);
        go(c + 2);
        chk("rearm_stop", 32'(armed), 32'd0);

        // PERIOD = 3 with 4-cycle pulses merges; STOP lets the pulse finish.
        wr(32'h0, c);
        wr(32'h0000_0301, c);
        go(c + 2);
        wr(32'h0000_0303, m);
        push(m + 2, 10, 9);
        go(m + 9);
        user_data_in = 32'h0000_0307;
        go(m + 11);
        chk("merge_stopped", 32'(running), 32'd0);
        chk("merge_tail_high", 32'(sync_out), 32'd1);
        chk("merge_count", 32'(sync_count), 32'd11);
        go(m + 16);
        chk("merge_tail_done", 32'(sync_out), 32'd0);

        // Reset in the middle of a pulse cuts it at once.
        wr(32'h0, c);
        wr(32'h1, c);
        go(c + 2);
        wr(32'h3, r);
        push(r + 2, 2, 12);
        go(r + 3);
        #2 user_rst = 1'b1;
        #1;
        chk("rst_mid_pulse", 32'(sync_out), 32'd0);
        chk("rst_mid_count", 32'(sync_count), 32'd0);
        chk("rst_mid_status", status_out, 32'h0000_0000);
        user_data_in = 32'h0;
        go(r + 6);
        user_rst = 1'b0;

        // 17 starts with a 4-bit counter wrap to 1.
        wr(32'h0000_0501, c);
        go(c + 2);
        chk("wrap_armed", 32'(armed), 32'd1);
        wr(32'h0000_0503, k);
        for (int i = 0; i < 17; i++) push(k + 2 + 5 * i, 4, (i + 1) % 16);
        go(k + 83);
        user_data_in = 32'h0000_0507;
        go(k + 95);
        chk("wrap_count", 32'(sync_count), 32'd1);
        chk("wrap_status", status_out, 32'h0001_0000);

        go(cyc + 5);
        chk("pending_pulses", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
